btn_debounce_counter: RTL and testbench

//  Input-side counterpart to the board's LED output path: conditions one raw push-button into a clean level,

---
 rtl/btn_pkg.sv | 31 +++
 rtl/btn_sync.sv | 32 +++
 rtl/btn_debounce_counter.sv | 175 +++++++++++++++++
 tb/tb_btn_debounce_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
// The debounce FSM state encoding lives here so that sub-blocks and checkers agree on it.
package btn_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        REL_STABLE = 2'd0,
        PRESS_PEND = 2'd1,
        PRS_STABLE = 2'd2,
        REL_PEND   = 2'd3
    } btn_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Metastability synchroniser for one asynchronous pin: STAGES-deep flop chain.
// Reset loads RST_VAL so the chain starts at the pin's idle level.
module btn_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw pin in at bit 0.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser chain register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_counter.sv
// Button conditioner: synchroniser, debounce FSM, press/release strobes and a wrapping press counter.
// Optional auto-repeat while held is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_counter
    import btn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEB_CYCLES     = 240000,
    parameter int unsigned BTN_ACTIVE_LOW = 1,
    parameter int unsigned COUNT_W        = 8,
    parameter int unsigned REPEAT_DELAY   = 6000000,
    parameter int unsigned REPEAT_PERIOD  = 1200000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               btn_press,
    output logic               btn_release,
    output logic [COUNT_W-1:0] press_count
);

    localparam int unsigned        CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 32'd1);
    localparam logic               PIN_IDLE = (BTN_ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;

    if (SYNC_STAGES < 32'd2) begin : g_bad_sync
        $error("btn_debounce_counter: SYNC_STAGES must be at least 2");
    end
    if (DEB_CYCLES < 32'd1 || REPEAT_DELAY < 32'd1 || REPEAT_PERIOD < 32'd1) begin : g_bad_timing
        $error("btn_debounce_counter: DEB_CYCLES and REPEAT_* must be at least 1");
    end

    logic               pin_sync_s;
    logic               btn_s;
    btn_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic [COUNT_W-1:0] count_q, count_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned      RPT_W      = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [RPT_W-1:0] RPT_NEXT   = RPT_W'(REPEAT_PERIOD - 32'd1);
    logic [RPT_W-1:0]            rpt_q, rpt_d;
    logic                        rpt_first_q, rpt_first_d;
`endif

    btn_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (PIN_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (pin_sync_s)
    );

    // Normalise so that 1 always means pressed.
    assign btn_s = pin_sync_s ^ PIN_IDLE;

    // Debounce FSM next-state, strobes, press counter and repeat timer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            REL_STABLE: begin
                if (btn_s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end else begin
                    state_d = REL_STABLE;
                end
            end
            PRESS_PEND: begin
                if (!btn_s) begin
                    state_d = REL_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS_STABLE;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + COUNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRS_STABLE: begin
                if (!btn_s) begin
                    state_d = REL_PEND;
                    cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
                end else if (rpt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                    press_d     = 1'b1;
                    count_d     = count_q + COUNT_W'(1);
                    rpt_d       = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
`else
                end else begin
                    state_d = PRS_STABLE;
                end
`endif
            end
            REL_PEND: begin
                if (btn_s) begin
                    // Release rejected as bounce: the hold time restarts from zero.
                    state_d = PRS_STABLE;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = REL_STABLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = REL_STABLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REL_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Randomised self-checking bench for btn_debounce_counter with a run-length reference model.
// Define BTN_AUTOREPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_btn_debounce_counter;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_in = 1'b1;
    logic          btn_level;
    logic          btn_press;
    logic          btn_release;
    logic [CW-1:0] press_count;

    int errors = 0;
    int checks = 0;
    int press_seen = 0;
    int rel_seen = 0;

    btn_debounce_counter #(
        .SYNC_STAGES    (SYNC),
        .DEB_CYCLES     (DEB),
        .BTN_ACTIVE_LOW (1),
        .COUNT_W        (CW),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the pressed level flips once DEB+1 consecutive synchronised
    // samples disagree with it; the synchronised sample is the pin seen SYNC edges earlier.
    logic          m_p1, m_p2, m_s;
    logic          m_level, m_press, m_rel;
    logic [CW-1:0] m_count;
    int            m_run, m_held;
    logic          m_first;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
                m_count = '0; m_run = 0; m_held = 0; m_first = 1'b1;
            end else begin
                m_s = m_p2;
                m_p2 = m_p1;
                m_p1 = (btn_in == 1'b0);
                m_press = 1'b0;
                m_rel = 1'b0;
                if (m_s != m_level) begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_level = m_s;
                        m_run = 0;
                        if (m_s) begin
                            m_press = 1'b1;
                            m_count++;
                            m_held = 0;
                            m_first = 1'b1;
                        end else begin
                            m_rel = 1'b1;
                        end
                    end
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (m_level && m_run > 0) begin
                        m_held = 0;
                        m_first = 1'b1;
                    end else if (m_level) begin
                        m_held++;
                        if (m_held == (m_first ? RD : RP)) begin
                            m_press = 1'b1;
                            m_count++;
                            m_held = 0;
                            m_first = 1'b0;
                        end
                    end
`endif
                    m_run = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus strobe tallies for directed checks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_level", int'(btn_level), 0);
                check("rst_press", int'(btn_press), 0);
                check("rst_release", int'(btn_release), 0);
                check("rst_count", int'(press_count), 0);
            end else begin
                check("level", int'(btn_level), int'(m_level));
                check("press", int'(btn_press), int'(m_press));
                check("release", int'(btn_release), int'(m_rel));
                check("count", int'(press_count), int'(m_count));
                check("no_both", int'(btn_press & btn_release), 0);
                if (btn_press) press_seen++;
                if (btn_release) rel_seen++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic pin);
        @(posedge clk); #1;
        rst = 1'b1;
        btn_in = pin;
        tick(2);
        rst = 1'b0;
    endtask

    int k, p0, r0, n;
    bit hit;

    initial begin
        // 1: reset with the pin held pressed
        btn_in = 1'b0;
        rst = 1'b1;
        tick(3);
        #4;
        check("t1_level_in_rst", int'(btn_level), 0);
        check("t1_count_in_rst", int'(press_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (btn_press) hit = 1'b1;
        end
        check("t1_press_seen", int'(hit), 1);
        check("t1_latency_ok", int'(k >= 6 && k <= 7), 1);
        btn_in = 1'b1;
        tick(12);

        // 2: clean press and release
        do_reset(1'b1);
        p0 = press_seen; r0 = rel_seen;
        btn_in = 1'b0;
        tick(20);
        check("t2_level", int'(btn_level), 1);
        check("t2_count", int'(press_count), 1);
        check("t2_presses", press_seen - p0, 1);
        btn_in = 1'b1;
        tick(12);
        check("t2_released", int'(btn_level), 0);
        check("t2_releases", rel_seen - r0, 1);

        // 3: bounce shorter than the debounce window
        do_reset(1'b1);
        p0 = press_seen;
        for (int i = 0; i < 5; i++) begin
            btn_in = 1'b0; tick(3);
            btn_in = 1'b1; tick(3);
        end
        tick(8);
        check("t3_presses", press_seen - p0, 0);
        check("t3_level", int'(btn_level), 0);
        check("t3_count", int'(press_count), 0);

        // 4: counter wrap
        do_reset(1'b1);
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b0; tick(8);
            btn_in = 1'b1; tick(8);
        end
        check("t4_wrap_zero", int'(press_count), 0);
        btn_in = 1'b0; tick(8);
        btn_in = 1'b1; tick(8);
        check("t4_wrap_one", int'(press_count), 1);

        // 5: reset while a press is pending
        do_reset(1'b1);
        p0 = press_seen;
        btn_in = 1'b0;
        tick(4);
        rst = 1'b1;
        btn_in = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12);
        check("t5_presses", press_seen - p0, 0);
        check("t5_count", int'(press_count), 0);
        check("t5_level", int'(btn_level), 0);

        // 6: long hold
        do_reset(1'b1);
        btn_in = 1'b0;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (btn_press) hit = 1'b1;
        end
        check("t6_accept_seen", int'(hit), 1);
        n = 1;
        repeat (59) begin
            @(posedge clk); #1;
            if (btn_press) n++;
        end
`ifdef BTN_AUTOREPEAT_EN
        check("t6_strobes", n, 6);
        check("t6_count", int'(press_count), 6);
`else
        check("t6_strobes", n, 1);
        check("t6_count", int'(press_count), 1);
`endif
        check("t6_level", int'(btn_level), 1);
        btn_in = 1'b1;
        tick(12);

        // 7: random pin activity with runs around and beyond the debounce window
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                tick(int'($urandom_range(20, 45)));
            end else begin
                tick(int'($urandom_range(1, 9)));
            end
        end
        btn_in = 1'b1;
        tick(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
